rv_ex_stage: RTL and testbench
==============================

Name: rv_ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the ID/EX pipeline registers produced by the decode stage.
- Selects forwarded operands, runs the ALU and branch comparator, and resolves branch/jump targets.
- Drives the PC redirect and the flush to IF/ID, and registers the results into the EX/MEM pipeline registers.

Parameters:
- XLEN, 32, datapath width (global define in rv_configs.v, not a module parameter).

Ports:
- i_ex_clk  in  1  clock
- i_ex_rstn  in  1  synchronous active-low reset
- i_ex_stall  in  1  from hazard unit; instruction held in EX must not advance
- i_ex_pc  in  XLEN  ID/EX PC
- i_ex_func3  in  3  ID/EX func3
- i_ex_ext_imm  in  XLEN  ID/EX extended immediate
- i_ex_is_branch, i_ex_is_jump, i_ex_is_load  in  1 each  ID/EX control
- i_ex_alu_ctrl  in  4  ALU op
- i_ex_alu_a_sel  in  1  0=rs1, 1=PC
- i_ex_alu_b_sel  in  1  0=rs2, 1=imm
- i_ex_dmem_we  in  1  store enable
- i_ex_dmem_bytectrl  in  3  store/load width code, passed through
- i_ex_rf_we  in  1  register write enable
- i_ex_rf_wa  in  5  destination register
- i_ex_rf_rd1, i_ex_rf_rd2  in  XLEN  ID/EX operand values
- i_ex_rf_wd_pre_sel  in  2  writeback pre-select
- i_ex_fwd_mem  in  XLEN  forwarded value from the MEM stage
- i_ex_fwd_wb  in  XLEN  forwarded value from the WB stage
- i_ex_fwd_a_sel, i_ex_fwd_b_sel  in  2 each  from hazard unit: 00=ID/EX, 01=MEM, 10=WB, 11=ID/EX
- o_ex_flush  out  1  combinational; flush IF/ID and ID/EX
- o_ex_pc_target  out  XLEN  combinational redirect PC
- o_ex_mem_alu_result  out  XLEN  registered
- o_ex_mem_rf_wd_pre  out  XLEN  registered preselected writeback data
- o_ex_mem_dmem_wd  out  XLEN  registered store data (forwarded rs2)
- o_ex_mem_dmem_we, o_ex_mem_is_load, o_ex_mem_rf_we  out  1 each  registered
- o_ex_mem_dmem_bytectrl  out  3  registered
- o_ex_mem_rf_wa  out  5  registered

Behaviour:
- Operand forwarding:
  - opA_fwd and opB_fwd are muxed from the fwd_*_sel codes; 11 behaves as 00.
  - ALU input A = alu_a_sel ? pc : opA_fwd.
  - ALU input B = alu_b_sel ? ext_imm : opB_fwd.
- alu_ctrl encoding, {func7_5, func3}:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
  - Any other code yields result 0.
  - Shifts use B[4:0]. All arithmetic is modulo 2^XLEN.
- Branch compare uses opA_fwd and opB_fwd, selected by func3:
  - BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - 010 and 011 are never taken.
- Target selection:
  - Branch: target = pc + ext_imm, from a dedicated adder.
  - Jump (JAL: a_sel=1; JALR: a_sel=0; b_sel=1, ADD): target = alu_result with bit0 forced to 0.
- taken = (is_branch & cmp_true) | is_jump.
- o_ex_flush = taken & ~i_ex_stall. While stalled, flush is suppressed; it asserts in the first unstalled cycle.
- o_ex_pc_target is valid whenever o_ex_flush=1; otherwise don't-care but deterministic.
- rf_wd_pre selection:
  - 00 = alu_result
  - 01 = pc + 4
  - 10 = ext_imm (LUI)
  - 11 = alu_result
- EX/MEM registers update on every clock edge, one-cycle latency:
  - Reset (rstn=0): all o_ex_mem_* = 0.
  - Else if i_ex_stall: capture a bubble. All o_ex_mem_* = 0, so rf_we=0 and dmem_we=0; the held ID/EX instruction advances later.
  - Else: capture the computed values; store data = opB_fwd.
- Reset has priority over stall.
- A zeroed (flushed) ID/EX bubble must produce no side effects: flush=0, rf_we=0, dmem_we=0.
- Reset mid-operation discards the in-flight instruction. No state persists beyond the EX/MEM registers.

Decomposition:
- Shared defines in rv_configs.v:
  - ALU op codes
  - fwd_sel codes
  - rf_wd_pre_sel codes
  - branch func3 codes
- Sub-modules:
  - rv_alu: combinational; a, b, alu_ctrl -> result.
  - Optional rv_branch_cmp: a, b, func3 -> cmp_true.
- Pipeline registers and forwarding muxes live in rv_ex_stage.

Test Plan:
1. ADD forwarding: rd1=5, fwd_mem=7, fwd_a_sel=01, b_sel=1, imm=3, ADD -> next cycle alu_result=10, rf_wd_pre=10, flush=0.
2. BNE taken: pc=0x100, imm=0x20, is_branch=1, func3=001, opA=1, opB=2 -> flush=1 and target=0x120 combinationally; EX/MEM rf_we=0, dmem_we=0. Repeat with opA=opB -> flush=0.
3. JALR: rs1 via WB fwd = 0x1003, imm=4, a_sel=0, is_jump=1, wd_pre_sel=01, pc=0x40 -> target=0x1006, flush=1, EX/MEM rf_wd_pre=0x44.
4. SRA/SLTU: A=0x80000000, B=4 -> SRA gives 0xF8000000; SLTU with A=1, B=0xFFFFFFFF gives 1, SLT gives 0.
5. Stall with a taken jump in EX: stall=1 -> flush=0 and EX/MEM loads bubble. Release stall -> flush=1 and correct EX/MEM values.
6. Reset asserted while a store is in EX: next edge all o_ex_mem_*=0. A zero-filled ID/EX input -> flush=0, no writes.

Source files
------------

// File: rtl/rv_ex_stage_pkg.sv
// Shared widths and encodings for the RV32I execute stage: ALU ops,
// forwarding selects, writeback pre-selects and branch func3 codes.
package rv_ex_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_PC4   = 2'b01;
    localparam logic [1:0] WD_IMM   = 2'b10;

    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;
    localparam logic [2:0] F3_BLTU  = 3'b110;
    localparam logic [2:0] F3_BGEU  = 3'b111;

    // Codes 010/011 are not branches and must never redirect.
    function automatic logic branch_cmp(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b,
                                        input logic [2:0]      func3);
        case (func3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) <  $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a <  b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_ex_stage_if.sv
// ID/EX inputs, forwarding/hazard controls and EX/MEM outputs of the
// execute stage; master is the pipeline around EX, slave is EX itself.
interface rv_ex_stage_if
    import rv_ex_stage_pkg::*;
    ;
    logic            i_ex_stall;
    logic [XLEN-1:0] i_ex_pc;
    logic [2:0]      i_ex_func3;
    logic [XLEN-1:0] i_ex_ext_imm;
    logic            i_ex_is_branch;
    logic            i_ex_is_jump;
    logic            i_ex_is_load;
    logic [3:0]      i_ex_alu_ctrl;
    logic            i_ex_alu_a_sel;
    logic            i_ex_alu_b_sel;
    logic            i_ex_dmem_we;
    logic [2:0]      i_ex_dmem_bytectrl;
    logic            i_ex_rf_we;
    logic [4:0]      i_ex_rf_wa;
    logic [XLEN-1:0] i_ex_rf_rd1;
    logic [XLEN-1:0] i_ex_rf_rd2;
    logic [1:0]      i_ex_rf_wd_pre_sel;
    logic [XLEN-1:0] i_ex_fwd_mem;
    logic [XLEN-1:0] i_ex_fwd_wb;
    logic [1:0]      i_ex_fwd_a_sel;
    logic [1:0]      i_ex_fwd_b_sel;

    logic            o_ex_flush;
    logic [XLEN-1:0] o_ex_pc_target;
    logic [XLEN-1:0] o_ex_mem_alu_result;
    logic [XLEN-1:0] o_ex_mem_rf_wd_pre;
    logic [XLEN-1:0] o_ex_mem_dmem_wd;
    logic            o_ex_mem_dmem_we;
    logic            o_ex_mem_is_load;
    logic            o_ex_mem_rf_we;
    logic [2:0]      o_ex_mem_dmem_bytectrl;
    logic [4:0]      o_ex_mem_rf_wa;

    modport master (
        output i_ex_stall, i_ex_pc, i_ex_func3, i_ex_ext_imm, i_ex_is_branch,
               i_ex_is_jump, i_ex_is_load, i_ex_alu_ctrl, i_ex_alu_a_sel,
               i_ex_alu_b_sel, i_ex_dmem_we, i_ex_dmem_bytectrl, i_ex_rf_we,
               i_ex_rf_wa, i_ex_rf_rd1, i_ex_rf_rd2, i_ex_rf_wd_pre_sel,
               i_ex_fwd_mem, i_ex_fwd_wb, i_ex_fwd_a_sel, i_ex_fwd_b_sel,
        input  o_ex_flush, o_ex_pc_target, o_ex_mem_alu_result,
               o_ex_mem_rf_wd_pre, o_ex_mem_dmem_wd, o_ex_mem_dmem_we,
               o_ex_mem_is_load, o_ex_mem_rf_we, o_ex_mem_dmem_bytectrl,
               o_ex_mem_rf_wa
    );

    modport slave (
        input  i_ex_stall, i_ex_pc, i_ex_func3, i_ex_ext_imm, i_ex_is_branch,
               i_ex_is_jump, i_ex_is_load, i_ex_alu_ctrl, i_ex_alu_a_sel,
               i_ex_alu_b_sel, i_ex_dmem_we, i_ex_dmem_bytectrl, i_ex_rf_we,
               i_ex_rf_wa, i_ex_rf_rd1, i_ex_rf_rd2, i_ex_rf_wd_pre_sel,
               i_ex_fwd_mem, i_ex_fwd_wb, i_ex_fwd_a_sel, i_ex_fwd_b_sel,
        output o_ex_flush, o_ex_pc_target, o_ex_mem_alu_result,
               o_ex_mem_rf_wd_pre, o_ex_mem_dmem_wd, o_ex_mem_dmem_we,
               o_ex_mem_is_load, o_ex_mem_rf_we, o_ex_mem_dmem_bytectrl,
               o_ex_mem_rf_wa
    );
endinterface

// File: rtl/rv_ex_stage_alu.sv
// Combinational RV32I integer ALU; op code is {func7[5], func3}.
module rv_alu
    import rv_ex_stage_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/rv_ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution,
// PC redirect/flush and the EX/MEM pipeline registers.
module rv_ex_stage
    import rv_ex_stage_pkg::*;
(
    input  logic         i_ex_clk,
    input  logic         i_ex_rstn,
    rv_ex_stage_if.slave ex
);
    logic [XLEN-1:0] opa_fwd, opb_fwd, alu_a, alu_b, alu_result;
    logic [XLEN-1:0] br_target, jmp_target, wd_pre;
    logic            cmp_true, taken;

    always_comb begin
        case (ex.i_ex_fwd_a_sel)
            FWD_MEM: opa_fwd = ex.i_ex_fwd_mem;
            FWD_WB:  opa_fwd = ex.i_ex_fwd_wb;
            default: opa_fwd = ex.i_ex_rf_rd1;
        endcase
        case (ex.i_ex_fwd_b_sel)
            FWD_MEM: opb_fwd = ex.i_ex_fwd_mem;
            FWD_WB:  opb_fwd = ex.i_ex_fwd_wb;
            default: opb_fwd = ex.i_ex_rf_rd2;
        endcase
    end

    assign alu_a = ex.i_ex_alu_a_sel ? ex.i_ex_pc      : opa_fwd;
    assign alu_b = ex.i_ex_alu_b_sel ? ex.i_ex_ext_imm : opb_fwd;

    rv_alu u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .alu_ctrl (ex.i_ex_alu_ctrl),
        .result   (alu_result)
    );

    // Branch target has its own adder so the ALU stays free for the compare
    // operands; jumps reuse the ALU sum (pc+imm or rs1+imm) with bit0 cleared.
    assign cmp_true   = branch_cmp(opa_fwd, opb_fwd, ex.i_ex_func3);
    assign br_target  = ex.i_ex_pc + ex.i_ex_ext_imm;
    assign jmp_target = {alu_result[XLEN-1:1], 1'b0};
    assign taken      = (ex.i_ex_is_branch & cmp_true) | ex.i_ex_is_jump;

    assign ex.o_ex_flush     = taken & ~ex.i_ex_stall;
    assign ex.o_ex_pc_target = ex.i_ex_is_jump ? jmp_target : br_target;

    always_comb begin
        case (ex.i_ex_rf_wd_pre_sel)
            WD_PC4:  wd_pre = ex.i_ex_pc + XLEN'(4);
            WD_IMM:  wd_pre = ex.i_ex_ext_imm;
            default: wd_pre = alu_result;
        endcase
    end

    // A stall holds the instruction in ID/EX, so EX/MEM receives a bubble.
    always_ff @(posedge i_ex_clk) begin
        if (!i_ex_rstn || ex.i_ex_stall) begin
            ex.o_ex_mem_alu_result    <= '0;
            ex.o_ex_mem_rf_wd_pre     <= '0;
            ex.o_ex_mem_dmem_wd       <= '0;
            ex.o_ex_mem_dmem_we       <= 1'b0;
            ex.o_ex_mem_is_load       <= 1'b0;
            ex.o_ex_mem_rf_we         <= 1'b0;
            ex.o_ex_mem_dmem_bytectrl <= '0;
            ex.o_ex_mem_rf_wa         <= '0;
        end else begin
            ex.o_ex_mem_alu_result    <= alu_result;
            ex.o_ex_mem_rf_wd_pre     <= wd_pre;
            ex.o_ex_mem_dmem_wd       <= opb_fwd;
            ex.o_ex_mem_dmem_we       <= ex.i_ex_dmem_we;
            ex.o_ex_mem_is_load       <= ex.i_ex_is_load;
            ex.o_ex_mem_rf_we         <= ex.i_ex_rf_we;
            ex.o_ex_mem_dmem_bytectrl <= ex.i_ex_dmem_bytectrl;
            ex.o_ex_mem_rf_wa         <= ex.i_ex_rf_wa;
        end
    end
endmodule

// File: tb/tb_rv_ex_stage.sv
// Directed self-checking bench for rv_ex_stage with hand-computed vectors.
module tb_rv_ex_stage;
    import rv_ex_stage_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    rv_ex_stage_if ex ();

    rv_ex_stage dut (
        .i_ex_clk  (clk),
        .i_ex_rstn (rstn),
        .ex        (ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_idex();
        ex.i_ex_stall = 0;           ex.i_ex_pc = '0;
        ex.i_ex_func3 = '0;          ex.i_ex_ext_imm = '0;
        ex.i_ex_is_branch = 0;       ex.i_ex_is_jump = 0;
        ex.i_ex_is_load = 0;         ex.i_ex_alu_ctrl = '0;
        ex.i_ex_alu_a_sel = 0;       ex.i_ex_alu_b_sel = 0;
        ex.i_ex_dmem_we = 0;         ex.i_ex_dmem_bytectrl = '0;
        ex.i_ex_rf_we = 0;           ex.i_ex_rf_wa = '0;
        ex.i_ex_rf_rd1 = '0;         ex.i_ex_rf_rd2 = '0;
        ex.i_ex_rf_wd_pre_sel = '0;  ex.i_ex_fwd_mem = '0;
        ex.i_ex_fwd_wb = '0;         ex.i_ex_fwd_a_sel = '0;
        ex.i_ex_fwd_b_sel = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [134:0] all_regs;
        @(negedge clk);
        rstn = 0;
        clr_idex();
        ex.i_ex_rf_we = 1; ex.i_ex_dmem_we = 1; ex.i_ex_rf_wa = 5'd9;
        ex.i_ex_rf_rd1 = 32'h55; ex.i_ex_rf_rd2 = 32'h66;
        step();
        all_regs = {ex.o_ex_mem_alu_result, ex.o_ex_mem_rf_wd_pre, ex.o_ex_mem_dmem_wd,
                    ex.o_ex_mem_dmem_we, ex.o_ex_mem_is_load, ex.o_ex_mem_rf_we,
                    ex.o_ex_mem_dmem_bytectrl, ex.o_ex_mem_rf_wa};
        checks++;
        if (all_regs !== '0) begin
            errors++; $display("FAIL reset_regs got %h expected 0", all_regs);
        end
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_add_fwd();
        @(negedge clk);
        clr_idex();
        ex.i_ex_rf_rd1 = 32'd5; ex.i_ex_fwd_mem = 32'd7; ex.i_ex_fwd_a_sel = FWD_MEM;
        ex.i_ex_alu_b_sel = 1; ex.i_ex_ext_imm = 32'd3; ex.i_ex_alu_ctrl = ALU_ADD;
        ex.i_ex_rf_we = 1; ex.i_ex_rf_wa = 5'd3;
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b0) begin
            errors++; $display("FAIL add_flush got %b expected 0", ex.o_ex_flush);
        end
        step();
        checks++;
        if (ex.o_ex_mem_alu_result !== 32'd10 || ex.o_ex_mem_rf_wd_pre !== 32'd10) begin
            errors++; $display("FAIL add_mem_fwd got alu=%h wd=%h expected 0000000a", ex.o_ex_mem_alu_result, ex.o_ex_mem_rf_wd_pre);
        end
        checks++;
        if (ex.o_ex_mem_rf_we !== 1'b1 || ex.o_ex_mem_rf_wa !== 5'd3) begin
            errors++; $display("FAIL add_rf got we=%b wa=%0d expected 1/3", ex.o_ex_mem_rf_we, ex.o_ex_mem_rf_wa);
        end
        // code 11 falls back to the ID/EX operand
        @(negedge clk);
        ex.i_ex_fwd_a_sel = 2'b11;
        step();
        checks++;
        if (ex.o_ex_mem_alu_result !== 32'd8) begin
            errors++; $display("FAIL add_fwd11 got %h expected 00000008", ex.o_ex_mem_alu_result);
        end
        @(negedge clk);
        ex.i_ex_fwd_a_sel = FWD_WB; ex.i_ex_fwd_wb = 32'd20;
        step();
        checks++;
        if (ex.o_ex_mem_alu_result !== 32'd23) begin
            errors++; $display("FAIL add_fwd_wb got %h expected 00000017", ex.o_ex_mem_alu_result);
        end
    endtask

    task automatic test_branch();
        // {func3, rd1, rd2, expected taken}
        logic [2:0]  f3 [6]  = '{3'b001, 3'b001, 3'b100, 3'b110, 3'b010, 3'b111};
        logic [31:0] va [6]  = '{32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        logic [31:0] vb [6]  = '{32'd2, 32'd1, 32'd1, 32'd1, 32'd2, 32'd1};
        logic        exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr_idex();
            ex.i_ex_pc = 32'h100; ex.i_ex_ext_imm = 32'h20; ex.i_ex_is_branch = 1;
            ex.i_ex_alu_ctrl = ALU_SUB; ex.i_ex_func3 = f3[i];
            ex.i_ex_rf_rd1 = va[i]; ex.i_ex_rf_rd2 = vb[i];
            #1;
            checks++;
            if (ex.o_ex_flush !== exp[i]) begin
                errors++; $display("FAIL branch_flush[%0d] got %b expected %b", i, ex.o_ex_flush, exp[i]);
            end
            if (exp[i]) begin
                checks++;
                if (ex.o_ex_pc_target !== 32'h120) begin
                    errors++; $display("FAIL branch_target[%0d] got %h expected 00000120", i, ex.o_ex_pc_target);
                end
            end
            step();
            checks++;
            if (ex.o_ex_mem_rf_we !== 1'b0 || ex.o_ex_mem_dmem_we !== 1'b0) begin
                errors++; $display("FAIL branch_we[%0d] got rf=%b dm=%b expected 0/0", i, ex.o_ex_mem_rf_we, ex.o_ex_mem_dmem_we);
            end
        end
    endtask

    task automatic test_jump();
        @(negedge clk);
        clr_idex();
        ex.i_ex_fwd_a_sel = FWD_WB; ex.i_ex_fwd_wb = 32'h1003; ex.i_ex_ext_imm = 32'd4;
        ex.i_ex_alu_b_sel = 1; ex.i_ex_is_jump = 1; ex.i_ex_alu_ctrl = ALU_ADD;
        ex.i_ex_rf_wd_pre_sel = WD_PC4; ex.i_ex_pc = 32'h40; ex.i_ex_rf_we = 1; ex.i_ex_rf_wa = 5'd1;
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b1 || ex.o_ex_pc_target !== 32'h1006) begin
            errors++; $display("FAIL jalr_redirect got flush=%b tgt=%h expected 1/00001006", ex.o_ex_flush, ex.o_ex_pc_target);
        end
        step();
        checks++;
        if (ex.o_ex_mem_rf_wd_pre !== 32'h44 || ex.o_ex_mem_alu_result !== 32'h1007) begin
            errors++; $display("FAIL jalr_mem got wd=%h alu=%h expected 00000044/00001007", ex.o_ex_mem_rf_wd_pre, ex.o_ex_mem_alu_result);
        end
        @(negedge clk);
        ex.i_ex_alu_a_sel = 1; ex.i_ex_pc = 32'h200; ex.i_ex_ext_imm = 32'h10;
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b1 || ex.o_ex_pc_target !== 32'h210) begin
            errors++; $display("FAIL jal_redirect got flush=%b tgt=%h expected 1/00000210", ex.o_ex_flush, ex.o_ex_pc_target);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  op [11] = '{ALU_SRA, ALU_SRL, ALU_SLTU, ALU_SLT, ALU_SUB, ALU_SLL,
                                 ALU_XOR, ALU_OR, ALU_AND, 4'b1111, ALU_SLT};
        logic [31:0] a  [11] = '{32'h80000000, 32'h80000000, 32'd1, 32'd1, 32'd3, 32'd1,
                                 32'hF0, 32'hF0, 32'hF0, 32'h12345678, 32'hFFFFFFFF};
        logic [31:0] b  [11] = '{32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h21,
                                 32'hFF, 32'h0F, 32'hFF, 32'd1, 32'd1};
        logic [31:0] r  [11] = '{32'hF8000000, 32'h08000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'd2,
                                 32'h0F, 32'hFF, 32'hF0, 32'd0, 32'd1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            clr_idex();
            ex.i_ex_alu_ctrl = op[i]; ex.i_ex_rf_rd1 = a[i]; ex.i_ex_rf_rd2 = b[i];
            ex.i_ex_rf_wd_pre_sel = 2'b11;
            step();
            checks++;
            if (ex.o_ex_mem_alu_result !== r[i] || ex.o_ex_mem_rf_wd_pre !== r[i]) begin
                errors++; $display("FAIL alu_op[%0d] got alu=%h wd=%h expected %h", i, ex.o_ex_mem_alu_result, ex.o_ex_mem_rf_wd_pre, r[i]);
            end
        end
        @(negedge clk);
        clr_idex();
        ex.i_ex_ext_imm = 32'hABCDE000; ex.i_ex_rf_wd_pre_sel = WD_IMM; ex.i_ex_rf_rd1 = 32'd1;
        step();
        checks++;
        if (ex.o_ex_mem_rf_wd_pre !== 32'hABCDE000) begin
            errors++; $display("FAIL lui_wd got %h expected abcde000", ex.o_ex_mem_rf_wd_pre);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        clr_idex();
        ex.i_ex_rf_rd1 = 32'h100; ex.i_ex_alu_b_sel = 1; ex.i_ex_ext_imm = 32'd8;
        ex.i_ex_rf_rd2 = 32'h11; ex.i_ex_fwd_mem = 32'hDEAD; ex.i_ex_fwd_b_sel = FWD_MEM;
        ex.i_ex_dmem_we = 1; ex.i_ex_dmem_bytectrl = 3'b010;
        step();
        checks++;
        if (ex.o_ex_mem_alu_result !== 32'h108 || ex.o_ex_mem_dmem_wd !== 32'hDEAD) begin
            errors++; $display("FAIL store_data got addr=%h wd=%h expected 00000108/0000dead", ex.o_ex_mem_alu_result, ex.o_ex_mem_dmem_wd);
        end
        checks++;
        if (ex.o_ex_mem_dmem_we !== 1'b1 || ex.o_ex_mem_dmem_bytectrl !== 3'b010 || ex.o_ex_mem_rf_we !== 1'b0) begin
            errors++; $display("FAIL store_ctrl got we=%b bc=%b rfwe=%b expected 1/010/0", ex.o_ex_mem_dmem_we, ex.o_ex_mem_dmem_bytectrl, ex.o_ex_mem_rf_we);
        end
        @(negedge clk);
        ex.i_ex_dmem_we = 0; ex.i_ex_is_load = 1; ex.i_ex_rf_we = 1; ex.i_ex_rf_wa = 5'd31;
        step();
        checks++;
        if (ex.o_ex_mem_is_load !== 1'b1 || ex.o_ex_mem_rf_wa !== 5'd31 || ex.o_ex_mem_dmem_we !== 1'b0) begin
            errors++; $display("FAIL load_ctrl got ld=%b wa=%0d we=%b expected 1/31/0", ex.o_ex_mem_is_load, ex.o_ex_mem_rf_wa, ex.o_ex_mem_dmem_we);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        clr_idex();
        ex.i_ex_pc = 32'h80; ex.i_ex_ext_imm = 32'h8; ex.i_ex_alu_a_sel = 1; ex.i_ex_alu_b_sel = 1;
        ex.i_ex_is_jump = 1; ex.i_ex_rf_we = 1; ex.i_ex_rf_wa = 5'd1; ex.i_ex_rf_wd_pre_sel = WD_PC4;
        ex.i_ex_stall = 1;
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b0) begin
            errors++; $display("FAIL stall_flush got %b expected 0", ex.o_ex_flush);
        end
        step();
        checks++;
        if (ex.o_ex_mem_rf_we !== 1'b0 || ex.o_ex_mem_rf_wd_pre !== 32'd0 || ex.o_ex_mem_rf_wa !== 5'd0) begin
            errors++; $display("FAIL stall_bubble got we=%b wd=%h wa=%0d expected 0/0/0", ex.o_ex_mem_rf_we, ex.o_ex_mem_rf_wd_pre, ex.o_ex_mem_rf_wa);
        end
        @(negedge clk);
        ex.i_ex_stall = 0;
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b1 || ex.o_ex_pc_target !== 32'h88) begin
            errors++; $display("FAIL unstall_redirect got flush=%b tgt=%h expected 1/00000088", ex.o_ex_flush, ex.o_ex_pc_target);
        end
        step();
        checks++;
        if (ex.o_ex_mem_rf_we !== 1'b1 || ex.o_ex_mem_rf_wd_pre !== 32'h84 || ex.o_ex_mem_rf_wa !== 5'd1) begin
            errors++; $display("FAIL unstall_mem got we=%b wd=%h wa=%0d expected 1/00000084/1", ex.o_ex_mem_rf_we, ex.o_ex_mem_rf_wd_pre, ex.o_ex_mem_rf_wa);
        end
    endtask

    task automatic test_reset_mid();
        logic [134:0] all_regs;
        @(negedge clk);
        clr_idex();
        ex.i_ex_rf_rd1 = 32'h300; ex.i_ex_rf_rd2 = 32'hBEEF; ex.i_ex_dmem_we = 1;
        ex.i_ex_dmem_bytectrl = 3'b001;
        step();
        @(negedge clk);
        rstn = 0;
        step();
        all_regs = {ex.o_ex_mem_alu_result, ex.o_ex_mem_rf_wd_pre, ex.o_ex_mem_dmem_wd,
                    ex.o_ex_mem_dmem_we, ex.o_ex_mem_is_load, ex.o_ex_mem_rf_we,
                    ex.o_ex_mem_dmem_bytectrl, ex.o_ex_mem_rf_wa};
        checks++;
        if (all_regs !== '0) begin
            errors++; $display("FAIL reset_mid got %h expected 0", all_regs);
        end
        @(negedge clk);
        rstn = 1;
        clr_idex();
        #1;
        checks++;
        if (ex.o_ex_flush !== 1'b0) begin
            errors++; $display("FAIL bubble_flush got %b expected 0", ex.o_ex_flush);
        end
        step();
        checks++;
        if (ex.o_ex_mem_rf_we !== 1'b0 || ex.o_ex_mem_dmem_we !== 1'b0) begin
            errors++; $display("FAIL bubble_we got rf=%b dm=%b expected 0/0", ex.o_ex_mem_rf_we, ex.o_ex_mem_dmem_we);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 0;
        clr_idex();
        test_reset();
        test_add_fwd();
        test_branch();
        test_jump();
        test_alu_ops();
        test_store();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
